// File: rtl/fetch_queue_if.sv
// Bus between the prefetch queue, the instruction ROM and the IF_ID stage.
// slave: the queue itself; master: whatever drives ROM data and pipeline control.
interface fetch_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_instruction;
   logic              LE;
   logic              branch_taken;
   logic [ADDR_W-1:0] target_addr;
   logic              out_valid;
   logic [DATA_W-1:0] out_instruction;
   logic [ADDR_W-1:0] out_next_pc;
   logic              full;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  rom_instruction, LE, branch_taken, target_addr,
      output rom_address, out_valid, out_instruction, out_next_pc, full, count
   );

   modport master (
      output rom_instruction, LE, branch_taken, target_addr,
      input  rom_address, out_valid, out_instruction, out_next_pc, full, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, reads one ROM word per cycle and buffers
// {instruction, PC+4} entries for IF_ID. Flushes and redirects on a taken branch.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for a zero-latency ROM-to-output path
// when the queue is empty.
module fetch_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input logic          clk,
   input logic          R,
   fetch_queue_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] next_pc;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            head;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, fetch_pc_inc;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty, pop, push, advance, bypass;

   assign fetch_pc_inc = fetch_pc_q + ADDR_W'(4);
   assign empty        = (count_q == '0);
   assign pop          = bus.LE & ~empty;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Bypass is gated by R so outputs read zero while reset is held.
   assign bypass  = R & empty & ~bus.branch_taken;
   // A bypassed word consumed directly by IF_ID is not enqueued, but the PC still moves on.
   assign push    = ~bus.branch_taken & ((count_q < CNT_W'(DEPTH)) | pop) & ~(bypass & bus.LE);
   assign advance = push | (bypass & bus.LE);
`else
   assign bypass  = 1'b0;
   assign push    = ~bus.branch_taken & ((count_q < CNT_W'(DEPTH)) | pop);
   assign advance = push;
`endif

   // Next-state for PC, pointers and occupancy; a taken branch overrides everything.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (bus.branch_taken) begin
         // Any head pop this cycle is subsumed by discarding every entry.
         fetch_pc_d = bus.target_addr;
         rd_ptr_d   = wr_ptr_q;
         count_d    = '0;
      end else begin
         if (push)    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         if (advance) fetch_pc_d = fetch_pc_inc;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         fetch_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Buffer storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{instr: bus.rom_instruction, next_pc: fetch_pc_inc};
      end
   end

   // Head presentation: NOP and zero PC whenever nothing valid is available.
   always_comb begin
      head                = mem_q[rd_ptr_q];
      bus.out_valid       = 1'b0;
      bus.out_instruction = '0;
      bus.out_next_pc     = '0;
      if (!empty) begin
         bus.out_valid       = 1'b1;
         bus.out_instruction = head.instr;
         bus.out_next_pc     = head.next_pc;
      end else if (bypass) begin
         bus.out_valid       = 1'b1;
         bus.out_instruction = bus.rom_instruction;
         bus.out_next_pc     = fetch_pc_inc;
      end
   end

   assign bus.rom_address = fetch_pc_q;
   assign bus.full        = (count_q == CNT_W'(DEPTH));
   assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. ROM model: word at byte address 4n holds n+1.
`timescale 1ns/1ps
module tb_fetch_queue;
   logic clk;
   logic R;
   int   n_assert;
   int   n_fail;

   fetch_queue_if #(.DEPTH(4), .ADDR_W(8), .DATA_W(32)) bus ();

   fetch_queue #(.DEPTH(4), .ADDR_W(8), .DATA_W(32)) u_dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ROM: ROM[n] = n + 1.
   always_comb bus.rom_instruction = 32'({2'b00, bus.rom_address[7:2]}) + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      R = 1'b0;
      @(negedge clk);
      R = 1'b1;
   endtask

   initial begin
      n_assert         = 0;
      n_fail           = 0;
      R                = 1'b1;
      bus.LE           = 1'b0;
      bus.branch_taken = 1'b0;
      bus.target_addr  = '0;
      #2 R = 1'b0;
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_instr", bus.out_instruction, 32'd0);
      check("rst_npc", 32'(bus.out_next_pc), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_addr", 32'(bus.rom_address), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
      // Bypass: ROM word visible in the very first cycle, consumed straight through.
      bus.LE = 1'b1;
      @(negedge clk);
      R = 1'b1;
      #1;
      for (int k = 1; k <= 4; k++) begin
         check("byp_valid", 32'(bus.out_valid), 32'd1);
         check("byp_instr", bus.out_instruction, 32'(k));
         check("byp_npc", 32'(bus.out_next_pc), 32'(4 * k));
         check("byp_count", 32'(bus.count), 32'd0);
         step();
      end
`else
      // Streaming with LE held high: one instruction per cycle, count steady at 1.
      bus.LE = 1'b1;
      @(negedge clk);
      R = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("stream_valid", 32'(bus.out_valid), 32'd1);
         check("stream_instr", bus.out_instruction, 32'(k));
         check("stream_npc", 32'(bus.out_next_pc), 32'(4 * k));
         check("stream_count", 32'(bus.count), 32'd1);
      end

      // Stall fill: LE low for 6 cycles saturates at DEPTH and freezes the PC.
      bus.LE = 1'b0;
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step();
         check("fill_count", 32'(bus.count), (i < 4) ? 32'(i) : 32'd4);
      end
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_addr", 32'(bus.rom_address), 32'd16);
      check("fill_head", bus.out_instruction, 32'd1);

      // Drain with LE high from full: push+pop keeps count at DEPTH, order preserved.
      bus.LE = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         step();
         check("drain_instr", bus.out_instruction, 32'(k));
         check("drain_count", 32'(bus.count), 32'd4);
      end

      // Branch with count = 3 and LE = 1.
      bus.LE = 1'b0;
      do_reset();
      repeat (3) step();
      check("pre_br_count", 32'(bus.count), 32'd3);
      check("pre_br_head", bus.out_instruction, 32'd1);
      bus.LE           = 1'b1;
      bus.branch_taken = 1'b1;
      bus.target_addr  = 8'd40;
      step();
      bus.branch_taken = 1'b0;
      check("br_valid", 32'(bus.out_valid), 32'd0);
      check("br_count", 32'(bus.count), 32'd0);
      check("br_addr", 32'(bus.rom_address), 32'd40);
      check("br_instr", bus.out_instruction, 32'd0);
      step();
      check("br_tgt_valid", 32'(bus.out_valid), 32'd1);
      check("br_tgt_npc", 32'(bus.out_next_pc), 32'd44);
      check("br_tgt_instr", bus.out_instruction, 32'd11);

      // Branch with LE = 0 still flushes.
      bus.LE           = 1'b0;
      bus.branch_taken = 1'b1;
      bus.target_addr  = 8'd100;
      step();
      bus.branch_taken = 1'b0;
      check("brs_count", 32'(bus.count), 32'd0);
      check("brs_addr", 32'(bus.rom_address), 32'd100);

      // Asynchronous reset mid-cycle with count = 3.
      repeat (3) step();
      check("pre_ar_count", 32'(bus.count), 32'd3);
      #3 R = 1'b0;
      #1;
      check("ar_valid", 32'(bus.out_valid), 32'd0);
      check("ar_instr", bus.out_instruction, 32'd0);
      check("ar_npc", 32'(bus.out_next_pc), 32'd0);
      check("ar_count", 32'(bus.count), 32'd0);
      check("ar_addr", 32'(bus.rom_address), 32'd0);

      // PC wrap: redirect to 252, then the stored next_pc and the PC wrap to 0.
      @(negedge clk);
      R                = 1'b1;
      bus.LE           = 1'b1;
      bus.branch_taken = 1'b1;
      bus.target_addr  = 8'd252;
      step();
      bus.branch_taken = 1'b0;
      check("wrap_pc", 32'(bus.rom_address), 32'd252);
      step();
      check("wrap_instr", bus.out_instruction, 32'd64);
      check("wrap_npc", 32'(bus.out_next_pc), 32'd0);
      check("wrap_addr", 32'(bus.rom_address), 32'd0);
      step();
      check("post_wrap_instr", bus.out_instruction, 32'd1);
      check("post_wrap_npc", 32'(bus.out_next_pc), 32'd4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue. It sits between the program counter/instruction ROM and the IF_ID pipeline register. It owns the fetch PC, reads one 32-bit instruction per cycle from the combinational ROM, and buffers up to DEPTH entries of {instruction, PC+4}. It presents the oldest entry to IF_ID, obeys the forwarding unit's load-enable stall, and flushes on a taken branch from the condition handler.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ADDR_W, 8: fetch-address width (byte address).
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- R  in  1  reset, asynchronous, active-low (0 = reset).
- rom_address  out  ADDR_W  current fetch PC to ROM; combinational from the fetch_pc register.
- rom_instruction  in  DATA_W  ROM data for rom_address, valid in the same cycle.
- LE  in  1  consumer advance; 1 = IF_ID loads this cycle (pop), 0 = stall.
- branch_taken  in  1  taken branch/BL resolved in ID; flush and redirect.
- target_addr  in  ADDR_W  redirect address, used when branch_taken = 1.
- out_valid  out  1  head entry valid.
- out_instruction  out  DATA_W  head instruction; 0 (NOP) when out_valid = 0.
- out_next_pc  out  ADDR_W  head PC+4; 0 when out_valid = 0.
- full  out  1  count == DEPTH.
- count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- State: fetch_pc, circular buffer, rd_ptr and wr_ptr (clog2(DEPTH) bits, wrap naturally), count.
- pop = LE & (count != 0).
- push = ~branch_taken & ((count < DEPTH) | pop).
- On push:
  - write {rom_instruction, fetch_pc+4} at wr_ptr;
  - wr_ptr += 1;
  - fetch_pc <= fetch_pc + 4.
- On pop: rd_ptr += 1.
- count updates by push − pop. Simultaneous push and pop when full is legal; count stays DEPTH.
- branch_taken (highest priority):
  - the head is still popped this cycle if LE = 1 (delay-slot instruction reaches IF_ID);
  - then all entries are discarded (count = 0, rd_ptr = wr_ptr);
  - fetch_pc <= target_addr;
  - that cycle's ROM word is not enqueued.
- If branch_taken and LE = 0 in the same cycle, the flush still happens and nothing is popped.
- LE = 0 with count = 0 has no effect on the queue.
- fetch_pc + 4 wraps modulo 2^ADDR_W (252 → 0 for ADDR_W = 8). The stored next_pc wraps the same way.
- Reset (R = 0, any time, mid-operation): fetch_pc = 0, pointers = 0, count = 0, out_valid = 0, out_instruction = 0, out_next_pc = 0, full = 0. Buffer contents need not be cleared. Release is sampled at the next rising edge.

## Timing
- rom_address changes only on clock edges.
- Without bypass, fetch-to-output latency is 1 cycle. The first valid output appears the cycle after the first edge with R = 1.
- After a flush, out_valid = 0 for exactly one cycle, then the target instruction appears (without bypass).
- Steady state with LE held at 1: one instruction per cycle, count settles at 1.
- LE = 0 for N cycles from count = 1 fills the queue. full asserts once count reaches DEPTH, and fetch_pc freezes.
- out_* are combinational from rd_ptr and buffer contents (plus bypass path if enabled). They are stable after the clock edge.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when count = 0 and branch_taken = 0, out_valid = 1 and out_instruction/out_next_pc come from rom_instruction/fetch_pc+4 combinationally;
  - if LE = 1 that word is consumed directly and not enqueued (push suppressed, count stays 0);
  - gives zero-cycle latency after reset and flush.
- Undefined: no bypass path; behaviour as in Timing.

## Test plan
- Reset then LE = 1 constant, ROM[n] = n+1:
  - cycle 1 after release: out_instruction = 1, out_next_pc = 4;
  - then 2/8, 3/12, …;
  - count = 1 steady.
- LE = 0 for 6 cycles, DEPTH = 4:
  - count rises to 4, full = 1, rom_address frozen at 16;
  - LE = 1 then drains in order 1,2,3,4 with no drop or duplicate.
- branch_taken = 1 with target_addr = 40, LE = 1, count = 3:
  - head popped;
  - next cycle out_valid = 0, count = 0, rom_address = 40;
  - following cycle out_next_pc = 44.
- fetch_pc = 252, LE = 1: entry next_pc = 0, rom_address wraps to 0.
- Assert R = 0 asynchronously mid-cycle with count = 3: all outputs go to 0 immediately, before the next edge.
- FETCH_QUEUE_BYPASS_EN defined, reset release:
  - out_valid = 1 in the first cycle with ROM[0] data;
  - count = 0 throughout while LE = 1.
